memory_readback: RTL and testbench

Read-side counterpart of the write arbiter: accepts a request for a contiguous run of DDR bursts, issues MIG read commands through the app_* command port, and streams the returned 256-bit words to a downstream capture-readout FIFO. Runs entirely in the MIG user clock domain. Flow control is by credits against downstream free space, because MIG read data cannot be backpressured.

---
 rtl/memory_readback.sv | 176 +++++++++++++++++
 tb/tb_memory_readback.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_readback.sv
// Read-side DDR burst sequencer: issues MIG READ commands under downstream credit and
// forwards returned words one cycle later. Optional perf counters: MEMORY_READBACK_PERF_EN.
module memory_readback #(
  parameter int BURST_STRIDE = 8,
  parameter int FIFO_MARGIN  = 4
) (
  input  logic         clk_ram,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [28:0]  req_addr,
  input  logic [15:0]  req_len,
  output logic         done,
  output logic [28:0]  app_addr,
  output logic [2:0]   app_cmd,
  output logic         app_en,
  input  logic         app_rdy,
  input  logic [255:0] app_rd_data,
  input  logic         app_rd_data_valid,
  input  logic         app_rd_data_end,
  output logic         rd_out_wr_en,
  output logic [255:0] rd_out_wr_data,
  output logic         rd_out_last,
  input  logic [9:0]   rd_out_free,
  output logic         err_underrun,
  output logic [1:0]   dbg_state,
  output logic [9:0]   dbg_inflight
`ifdef MEMORY_READBACK_PERF_EN
  ,
  output logic [31:0]  perf_cmds,
  output logic [31:0]  perf_words,
  output logic [31:0]  perf_credit_stalls
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

  state_t         state_q, state_d;
  logic [28:0]    cmd_addr_q, cmd_addr_d;
  logic [15:0]    cmds_left_q, cmds_left_d;
  logic [16:0]    words_left_q, words_left_d;
  logic [9:0]     inflight_q, inflight_d;
  logic           hold_q, hold_d;
  logic           req_ready_q, req_ready_d;
  logic           done_q, done_d;
  logic           wr_en_q, wr_en_d;
  logic [255:0]   wr_data_q, wr_data_d;
  logic           last_q, last_d;
  logic           err_q, err_d;

  logic accept, credit_ok, app_en_c, retire, data_ok, final_word;

  // Handshakes: a request transfers on req_valid && req_ready; a command transfers on
  // app_en && app_rdy, and once app_en is raised it stays up with a stable address until then.
  always_comb begin
    accept     = req_valid && req_ready_q;
    credit_ok  = ({1'b0, inflight_q} + 11'(FIFO_MARGIN + 2)) <= {1'b0, rd_out_free};
    app_en_c   = (state_q == ISSUE) && (hold_q || credit_ok);
    retire     = app_en_c && app_rdy;
    data_ok    = app_rd_data_valid && (inflight_q != 10'd0);
    final_word = data_ok && (words_left_q == 17'd1);

    state_d      = state_q;
    cmd_addr_d   = cmd_addr_q;
    cmds_left_d  = cmds_left_q;
    words_left_d = words_left_q;
    hold_d       = app_en_c && !app_rdy;
    done_d       = final_word;
    wr_en_d      = data_ok;
    wr_data_d    = data_ok ? app_rd_data : wr_data_q;
    last_d       = final_word;
    inflight_d   = inflight_q + (retire ? 10'd2 : 10'd0) - (data_ok ? 10'd1 : 10'd0);
    // Data with nothing outstanding, or a burst end on the first word of a pair, is an error.
    err_d        = err_q
                 || (app_rd_data_valid && (inflight_q == 10'd0))
                 || (data_ok && app_rd_data_end && !words_left_q[0]);

    if (data_ok) words_left_d = words_left_q - 17'd1;
    if (retire) begin
      cmd_addr_d  = cmd_addr_q + 29'(BURST_STRIDE);
      cmds_left_d = cmds_left_q - 16'd1;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          cmd_addr_d   = req_addr;
          cmds_left_d  = req_len;
          words_left_d = {req_len, 1'b0};
          if (req_len == 16'd0) done_d = 1'b1;
          else                  state_d = ISSUE;
        end
      end
      ISSUE: if (retire && (cmds_left_q == 16'd1)) state_d = DRAIN;
      DRAIN: if (final_word) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE) && !done_d;
  end

  always_ff @(posedge clk_ram) begin
    if (rst) begin
      state_q      <= IDLE;
      cmd_addr_q   <= '0;
      cmds_left_q  <= '0;
      words_left_q <= '0;
      inflight_q   <= '0;
      hold_q       <= 1'b0;
      req_ready_q  <= 1'b0;
      done_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      last_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_addr_q   <= cmd_addr_d;
      cmds_left_q  <= cmds_left_d;
      words_left_q <= words_left_d;
      inflight_q   <= inflight_d;
      hold_q       <= hold_d;
      req_ready_q  <= req_ready_d;
      done_q       <= done_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      last_q       <= last_d;
      err_q        <= err_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign done           = done_q;
  assign app_en         = app_en_c;
  assign app_addr       = cmd_addr_q;
  assign app_cmd        = app_en_c ? 3'b001 : 3'b000;
  assign rd_out_wr_en   = wr_en_q;
  assign rd_out_wr_data = wr_data_q;
  assign rd_out_last    = last_q;
  assign err_underrun   = err_q;
  assign dbg_state      = state_q;
  assign dbg_inflight   = inflight_q;

`ifdef MEMORY_READBACK_PERF_EN
  logic [31:0] perf_cmds_q, perf_cmds_d;
  logic [31:0] perf_words_q, perf_words_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_cmds_d  = perf_cmds_q;
    perf_words_d = perf_words_q;
    perf_stall_d = perf_stall_q;
    if (retire && (perf_cmds_q != 32'hFFFF_FFFF)) perf_cmds_d = perf_cmds_q + 32'd1;
    if (data_ok && (perf_words_q != 32'hFFFF_FFFF)) perf_words_d = perf_words_q + 32'd1;
    if ((state_q == ISSUE) && !app_en_c && (perf_stall_q != 32'hFFFF_FFFF))
      perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk_ram) begin
    if (rst) begin
      perf_cmds_q  <= '0;
      perf_words_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_cmds_q  <= perf_cmds_d;
      perf_words_q <= perf_words_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_cmds          = perf_cmds_q;
  assign perf_words         = perf_words_q;
  assign perf_credit_stalls = perf_stall_q;
`endif

endmodule

// File: tb/tb_memory_readback.sv
// Bench for memory_readback: a behavioural MIG (command queue + fixed-latency return)
// and a scoreboard of expected downstream words, addresses and in-flight count.
module tb_memory_readback;
  localparam int STRIDE = 8;

  logic         clk_ram = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [28:0]  req_addr;
  logic [15:0]  req_len;
  logic         done;
  logic [28:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy;
  logic [255:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         app_rd_data_end;
  logic         rd_out_wr_en;
  logic [255:0] rd_out_wr_data;
  logic         rd_out_last;
  logic [9:0]   rd_out_free;
  logic         err_underrun;
  logic [1:0]   dbg_state;
  logic [9:0]   dbg_inflight;
`ifdef MEMORY_READBACK_PERF_EN
  logic [31:0]  perf_cmds, perf_words, perf_credit_stalls;
`endif

  memory_readback dut (
    .clk_ram(clk_ram), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .done(done),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end),
    .rd_out_wr_en(rd_out_wr_en), .rd_out_wr_data(rd_out_wr_data), .rd_out_last(rd_out_last),
    .rd_out_free(rd_out_free), .err_underrun(err_underrun),
    .dbg_state(dbg_state), .dbg_inflight(dbg_inflight)
`ifdef MEMORY_READBACK_PERF_EN
    , .perf_cmds(perf_cmds), .perf_words(perf_words), .perf_credit_stalls(perf_credit_stalls)
`endif
  );

  // clock / reset block
  always #5 clk_ram = ~clk_ram;

  int checks = 0;
  int failures = 0;

  // behavioural MIG + scoreboard state
  int           cyc = 0;
  int           lat = 4;
  bit           rdy_rand = 1'b0;
  int           rdy_low = 0;
  bit           bad_end = 1'b0;
  bit           inject = 1'b0;
  int           due_q[$];
  logic [255:0] dat_q[$];
  bit           end_q[$];
  logic [255:0] exp_q[$];
  logic [28:0]  exp_addr_q[$];
  int           ret_cyc_q[$];
  int           stale_n = 0;
  int           out_cur = 0;
  int           out_next = 0;
  int           max_out = 0;
  int           tb_words_left = 0;
  bit           zero_due = 1'b0;
  int           done_cnt = 0;
  int           hold_cnt = 0;
  int           acc_cyc = 0;
  bit           mon_en = 1'b0;
  bit           prev_en = 1'b0;
  bit           prev_rdy = 1'b1;
  logic [28:0]  prev_addr = '0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // MIG model: acts 2 time units after each rising edge.
  initial begin
    logic [255:0] d;
    bit en_now;
    forever begin
      @(posedge clk_ram); #2;
      cyc++;
      out_cur = out_next;
      en_now = (app_en === 1'b1);
      if (rdy_low > 0 && en_now) begin
        app_rdy = 1'b0;
        rdy_low--;
      end else if (rdy_rand) app_rdy = 1'($urandom_range(0, 1));
      else app_rdy = 1'b1;
      if (prev_en && !prev_rdy) begin
        hold_cnt++;
        chk("hold_en", app_en, 1'b1);
        chk("hold_addr", app_addr, prev_addr);
      end
      if (en_now && app_rdy) begin
        if (exp_addr_q.size() == 0) chk("spurious_cmd_en", app_en, 1'b0);
        else chk("cmd_addr", app_addr, exp_addr_q.pop_front());
        chk("cmd_code", app_cmd, 3'b001);
        ret_cyc_q.push_back(cyc);
        for (int w = 0; w < 2; w++) begin
          for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
          due_q.push_back(cyc + lat);
          dat_q.push_back(d);
          end_q.push_back((w == 1) || bad_end);
          bad_end = 1'b0;
        end
        out_next += 2;
      end
      prev_en = en_now; prev_rdy = app_rdy; prev_addr = app_addr;
      app_rd_data_valid = 1'b0;
      app_rd_data_end = 1'b0;
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        void'(due_q.pop_front());
        d = dat_q.pop_front();
        app_rd_data_valid = 1'b1;
        app_rd_data_end = end_q.pop_front();
        app_rd_data = d;
        if (stale_n > 0) stale_n--;
        else begin
          exp_q.push_back(d);
          out_next--;
        end
      end else if (inject) begin
        for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
        app_rd_data = d;
        app_rd_data_valid = 1'b1;
        inject = 1'b0;
      end
      if (out_next > max_out) max_out = out_next;
    end
  end

  // scoreboard monitor on the falling edge
  initial begin
    bit exp_last;
    forever begin
      @(negedge clk_ram);
      if (mon_en) begin
        exp_last = (rd_out_wr_en === 1'b1) && (tb_words_left == 1);
        if (rd_out_wr_en === 1'b1) begin
          if (exp_q.size() == 0) chk("spurious_wr_en", rd_out_wr_en, 1'b0);
          else chk("rd_data", rd_out_wr_data, exp_q.pop_front());
          chk("rd_last", rd_out_last, exp_last);
          if (tb_words_left > 0) tb_words_left--;
        end else chk("rd_last_idle", rd_out_last, 1'b0);
        chk("done", done, exp_last || zero_due);
        zero_due = 1'b0;
        if (done === 1'b1) done_cnt++;
        chk("inflight", dbg_inflight, 10'(out_cur));
      end
    end
  end

  // driver tasks
  task automatic do_reset(input int n);
    @(posedge clk_ram); #1 rst = 1'b1;
    @(posedge clk_ram); #1;
    exp_q.delete(); exp_addr_q.delete();
    stale_n = due_q.size();
    out_cur = 0; out_next = 0; tb_words_left = 0; zero_due = 1'b0;
    prev_en = 1'b0; rdy_low = 0; bad_end = 1'b0; req_valid = 1'b0;
    for (int i = 1; i < n; i++) begin @(posedge clk_ram); #1; end
    rst = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    @(negedge clk_ram);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_app_en", app_en, 1'b0);
    chk("rst_app_cmd", app_cmd, 3'b000);
    chk("rst_app_addr", app_addr, 29'h0);
    chk("rst_wr_en", rd_out_wr_en, 1'b0);
    chk("rst_wr_data", rd_out_wr_data, 256'h0);
    chk("rst_last", rd_out_last, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err_underrun, 1'b0);
    chk("rst_state", dbg_state, 2'd0);
    chk("rst_inflight", dbg_inflight, 10'd0);
  endtask

  task automatic do_req(input logic [28:0] a, input logic [15:0] n);
    int t = 0;
    @(posedge clk_ram); #1;
    while (req_ready !== 1'b1 && t < 300) begin @(posedge clk_ram); #1; t++; end
    chk("req_ready_wait", req_ready, 1'b1);
    req_valid = 1'b1; req_addr = a; req_len = n;
    @(posedge clk_ram); #1;
    req_valid = 1'b0; req_addr = 29'($urandom); req_len = 16'($urandom);
    acc_cyc = cyc;
    tb_words_left = 2 * int'(n);
    for (int i = 0; i < int'(n); i++) exp_addr_q.push_back(a + 29'(i * STRIDE));
    zero_due = (n == 16'd0);
  endtask

  task automatic wait_done(input int budget);
    int start = done_cnt;
    int t = 0;
    while (done_cnt == start && t < budget) begin @(posedge clk_ram); #1; t++; end
    chk("done_seen", done_cnt - start, 1);
    chk("words_all_out", tb_words_left, 0);
    chk("exp_q_empty", exp_q.size(), 0);
  endtask

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0;
    app_rdy = 1'b0; app_rd_data = '0; app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
    rd_out_free = 10'd512;

    do_reset(2);
    chk_reset_outputs();
    @(posedge clk_ram); #1;
    chk("req_ready_after_rst", req_ready, 1'b1);
    mon_en = 1'b1;

    // basic read: three bursts issued on consecutive cycles, six words out
    lat = 6; ret_cyc_q.delete();
    do_req(29'h100, 16'd3);
    wait_done(200);
    chk("basic_cmd_count", ret_cyc_q.size(), 3);
    for (int i = 0; i < ret_cyc_q.size(); i++) chk("basic_cmd_cycle", ret_cyc_q[i], acc_cyc + 1 + i);

    // randomized requests with random app_rdy, latency and free space
    rdy_rand = 1'b1;
    for (int r = 0; r < 6; r++) begin
      lat = $urandom_range(1, 12);
      rd_out_free = 10'($urandom_range(6, 600));
      do_req(29'($urandom), 16'($urandom_range(1, 6)));
      wait_done(3000);
    end
    rdy_rand = 1'b0; rd_out_free = 10'd512;

    // app_rdy held low for five cycles while a command is pending
    lat = 3; t = hold_cnt; rdy_low = 5;
    do_req(29'h2000, 16'd4);
    wait_done(300);
    chk("backpressure_hold_cycles", hold_cnt - t, 5);

    // credit limit: 8 free slots, long return latency
    lat = 20; rd_out_free = 10'd8; max_out = 0;
    do_req(29'h4000, 16'd10);
    wait_done(1500);
    chk("credit_max_inflight", max_out, 4);
    rd_out_free = 10'd512;

    // address wrap at the top of the 29-bit space
    lat = 4;
    do_req(29'h1FFFFFF8, 16'd2);
    wait_done(200);
    chk("err_clean", err_underrun, 1'b0);

    // burst end reported on the first word of a pair
    bad_end = 1'b1;
    do_req(29'h300, 16'd2);
    wait_done(200);
    chk("err_bad_end", err_underrun, 1'b1);

    // zero-length request and unsolicited read data
    do_reset(1);
    chk_reset_outputs();
    do_req(29'h500, 16'd0);
    @(negedge clk_ram);
    chk("zero_no_app_en", app_en, 1'b0);
    chk("zero_ready_low_on_done", req_ready, 1'b0);
    @(negedge clk_ram);
    chk("zero_no_app_en2", app_en, 1'b0);
    chk("zero_ready_back", req_ready, 1'b1);
    chk("zero_err_clean", err_underrun, 1'b0);
    @(posedge clk_ram); #1 inject = 1'b1;
    repeat (4) @(posedge clk_ram);
    #1 chk("unsolicited_err", err_underrun, 1'b1);

    // reset mid-drain, then flush stale data and run a one-burst request
    do_reset(1);
    lat = 10;
    do_req(29'h600, 16'd3);
    t = 0;
    while (tb_words_left != 4 && t < 500) begin @(posedge clk_ram); #1; t++; end
    chk("drain_two_words", tb_words_left, 4);
    do_reset(1);
    chk_reset_outputs();
    t = 0;
    while (due_q.size() > 0 && t < 500) begin @(posedge clk_ram); #1; t++; end
    repeat (2) @(posedge clk_ram);
    #1 chk("stale_flagged", err_underrun, 1'b1);
    lat = 4;
    do_req(29'h700, 16'd1);
    wait_done(200);
    chk("err_sticky", err_underrun, 1'b1);

    repeat (3) @(posedge clk_ram);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
